multi_frame_buffer: RTL and testbench

- Parametrised successor to the two-bank frame store: N-bank (2 or 3) frame buffer with explicit publish/swap handshake between renderer and VGA scan-out. Single clock domain (pixel_clk).
- Renderer writes palette indices into a back bank and pulses wr_frame_done. The scan-out side pulses frame_complete at end of frame; the newest completed bank is then displayed.
- Adds bank-state tracking, writer back-pressure, blank output before the first publish, and drop/repeat statistics.
- Sits between the renderer and the palette lookup.

---
 rtl/fb_pkg.sv | 18 +
 rtl/frame_bank.sv | 21 ++
 rtl/multi_frame_buffer.sv | 153 +++++++++++++++
 tb/tb_multi_frame_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared bank-state type and allocation helper for the multi-bank frame buffer.
package fb_pkg;

  localparam int BUF_IDX_W = 2;

  typedef enum logic [1:0] {FREE, WRITING, READY, DISPLAY} buf_state_t;

  // Lowest set bit of free_mask wins; callers only use the result when the mask is non-zero.
  function automatic logic [BUF_IDX_W-1:0] lowest_free(input logic [3:0] free_mask);
    logic [BUF_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (free_mask[i]) idx = BUF_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame bank: simple dual-port RAM with a single-cycle registered read.
module frame_bank #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic              pixel_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge pixel_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multi_frame_buffer.sv
// N-bank frame store with a publish/swap handshake between the renderer and scan-out,
// writer back-pressure, blanking before the first published frame, and drop/repeat statistics.
module multi_frame_buffer
  import fb_pkg::*;
#(
  parameter int               NUM_BUFFERS  = 3,
  parameter int               ADDR_W       = 16,
  parameter int               FRAME_PIXELS = 64000,
  parameter int               PIX_W        = 8,
  parameter logic [PIX_W-1:0] BLANK_INDEX  = '0,
  parameter int               CNT_W        = 16
) (
  input  logic                 pixel_clk,
  input  logic                 RESET,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PIX_W-1:0]     wr_data,
  input  logic                 wr_frame_done,
  output logic                 wr_ready,
  output logic                 wr_overflow,
  input  logic                 frame_complete,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PIX_W-1:0]     pix_index,
  output logic [BUF_IDX_W-1:0] disp_idx,
  output logic [BUF_IDX_W-1:0] wr_idx,
  output logic [CNT_W-1:0]     frames_repeated,
  output logic [CNT_W-1:0]     frames_dropped
);

  localparam logic [ADDR_W:0] FRAME_LIM = (ADDR_W+1)'(FRAME_PIXELS);

  // Arrays are sized for the 2-bit bank index; slots at or above NUM_BUFFERS never leave FREE
  // and are excluded from allocation.
  buf_state_t bank_state [0:3];
  buf_state_t nxt_state  [0:3];

  logic [BUF_IDX_W-1:0] nxt_disp, nxt_wr, ready_idx, new_disp;
  logic [3:0]           free_mask;
  logic                 nxt_wr_ready, nxt_shown, shown, has_ready, done_ok, drop_inc, repeat_inc;
  logic                 wr_fire, rd_blank_q;
  logic [BUF_IDX_W-1:0] rd_sel_q;
  logic [PIX_W-1:0]     bank_q [0:3];

  // A completed frame is retired first, then the swap may consume it, then the writer takes
  // whatever bank is left free, so the simultaneous case falls out of the ordering.
  always_comb begin
    nxt_state    = bank_state;
    nxt_disp     = disp_idx;
    nxt_wr       = wr_idx;
    nxt_wr_ready = wr_ready;
    nxt_shown    = shown;
    drop_inc     = 1'b0;
    repeat_inc   = 1'b0;
    has_ready    = 1'b0;
    ready_idx    = '0;
    new_disp     = disp_idx;
    free_mask    = '0;
    done_ok      = wr_frame_done && wr_ready;

    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (bank_state[i] == READY) begin
        has_ready = 1'b1;
        ready_idx = BUF_IDX_W'(i);
      end
    end

    if (done_ok) begin
      if (has_ready) begin
        nxt_state[ready_idx] = FREE;
        drop_inc             = 1'b1;
      end
      nxt_state[wr_idx] = READY;
    end

    if (frame_complete) begin
      if (done_ok || has_ready) begin
        new_disp            = done_ok ? wr_idx : ready_idx;
        nxt_state[disp_idx] = FREE;
        nxt_state[new_disp] = DISPLAY;
        nxt_disp            = new_disp;
        nxt_shown           = 1'b1;
      end else begin
        repeat_inc = 1'b1;
      end
    end

    if (done_ok || !wr_ready) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        free_mask[i] = (nxt_state[i] == FREE);
      end
      nxt_wr_ready = |free_mask;
      if (|free_mask) begin
        nxt_wr            = lowest_free(free_mask);
        nxt_state[nxt_wr] = WRITING;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        bank_state[i] <= (i == 0) ? DISPLAY : (i == 1) ? WRITING : FREE;
      end
      disp_idx        <= BUF_IDX_W'(0);
      wr_idx          <= BUF_IDX_W'(1);
      wr_ready        <= 1'b1;
      wr_overflow     <= 1'b0;
      shown           <= 1'b0;
      frames_dropped  <= '0;
      frames_repeated <= '0;
    end else begin
      bank_state <= nxt_state;
      disp_idx   <= nxt_disp;
      wr_idx     <= nxt_wr;
      wr_ready   <= nxt_wr_ready;
      shown      <= nxt_shown;
      if (wr_en && !wr_ready) wr_overflow <= 1'b1;
      if (drop_inc && frames_dropped != '1) frames_dropped <= frames_dropped + CNT_W'(1);
      if (repeat_inc && frames_repeated != '1) frames_repeated <= frames_repeated + CNT_W'(1);
    end
  end

  assign wr_fire = wr_en && wr_ready && ({1'b0, wr_addr} < FRAME_LIM);

  for (genvar g = 0; g < 4; g++) begin : g_bank
    if (g < NUM_BUFFERS) begin : g_real
      frame_bank #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_bank (
        .pixel_clk (pixel_clk),
        .wr_en     (wr_fire && (wr_idx == BUF_IDX_W'(g))),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (bank_q[g])
      );
    end else begin : g_absent
      assign bank_q[g] = BLANK_INDEX;
    end
  end

  // Bank select and blanking travel with the address so a swap never splits a pixel.
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      rd_sel_q   <= '0;
      rd_blank_q <= 1'b1;
      pix_index  <= BLANK_INDEX;
    end else begin
      rd_sel_q   <= disp_idx;
      rd_blank_q <= !shown || ({1'b0, rd_addr} >= FRAME_LIM);
      pix_index  <= rd_blank_q ? BLANK_INDEX : bank_q[rd_sel_q];
    end
  end

endmodule

// File: tb/tb_multi_frame_buffer.sv
// Bench for multi_frame_buffer: a 3-bank and a 2-bank instance share one stimulus stream and
// are both checked every cycle against a bank-index model, plus hand-computed spot values.
module tb_multi_frame_buffer;

  localparam int         AW    = 5;
  localparam int         FP    = 20;
  localparam int         PW    = 8;
  localparam int         CW    = 3;
  localparam logic [7:0] BLANK = 8'hEE;
  localparam int         MAXC  = (1 << CW) - 1;

  logic          pixel_clk = 1'b0;
  logic          RESET = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          frame_complete = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [PW-1:0] wr_data = '0;

  logic          ready3, ovf3, ready2, ovf2;
  logic [1:0]    disp3, widx3, disp2, widx2;
  logic [PW-1:0] pix3, pix2;
  logic [CW-1:0] rep3, drop3, rep2, drop2;

  int checks = 0;
  int failures = 0;

  // Model per instance (0 = 3 banks, 1 = 2 banks): bank indices, -1 meaning "none".
  int m_disp [2];
  int m_wr   [2];
  int m_rdy  [2];
  int m_rep  [2];
  int m_drop [2];
  int m_s1   [2];
  int m_pix  [2];
  bit m_shown[2];
  bit m_ovf  [2];
  int m_mem  [2][3][32];

  always #5 pixel_clk = ~pixel_clk;

  multi_frame_buffer #(
    .NUM_BUFFERS(3), .ADDR_W(AW), .FRAME_PIXELS(FP), .PIX_W(PW), .BLANK_INDEX(BLANK), .CNT_W(CW)
  ) u3 (
    .pixel_clk(pixel_clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(ready3), .wr_overflow(ovf3),
    .frame_complete(frame_complete), .rd_addr(rd_addr), .pix_index(pix3),
    .disp_idx(disp3), .wr_idx(widx3), .frames_repeated(rep3), .frames_dropped(drop3)
  );

  multi_frame_buffer #(
    .NUM_BUFFERS(2), .ADDR_W(AW), .FRAME_PIXELS(FP), .PIX_W(PW), .BLANK_INDEX(BLANK), .CNT_W(CW)
  ) u2 (
    .pixel_clk(pixel_clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(ready2), .wr_overflow(ovf2),
    .frame_complete(frame_complete), .rd_addr(rd_addr), .pix_index(pix2),
    .disp_idx(disp2), .wr_idx(widx2), .frames_repeated(rep2), .frames_dropped(drop2)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  // One clock of the abstract model, using the inputs present at this edge.
  task automatic modelStep(input int k, input int nb);
    if (RESET) begin
      m_disp[k] = 0; m_wr[k] = 1; m_rdy[k] = -1; m_shown[k] = 1'b0;
      m_rep[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
      m_s1[k] = int'(BLANK); m_pix[k] = int'(BLANK);
      return;
    end
    m_pix[k] = m_s1[k];
    if (!m_shown[k] || int'(rd_addr) >= FP) m_s1[k] = int'(BLANK);
    else m_s1[k] = m_mem[k][m_disp[k]][rd_addr];
    if (wr_en) begin
      if (m_wr[k] < 0) m_ovf[k] = 1'b1;
      else if (int'(wr_addr) < FP) m_mem[k][m_wr[k]][wr_addr] = int'(wr_data);
    end
    if (wr_frame_done && m_wr[k] >= 0) begin
      if (m_rdy[k] >= 0) m_drop[k] = sat(m_drop[k]);
      m_rdy[k] = m_wr[k];
      m_wr[k]  = -1;
    end
    if (frame_complete) begin
      if (m_rdy[k] >= 0) begin
        m_disp[k] = m_rdy[k]; m_rdy[k] = -1; m_shown[k] = 1'b1;
      end else begin
        m_rep[k] = sat(m_rep[k]);
      end
    end
    if (m_wr[k] < 0) begin
      for (int b = nb - 1; b >= 0; b--) begin
        if (b != m_disp[k] && b != m_rdy[k]) m_wr[k] = b;
      end
    end
  endtask

  task automatic checkDut(input int k, input string tag, input logic rdy, input logic [1:0] widx,
                          input logic [1:0] didx, input logic ovf, input logic [CW-1:0] rep,
                          input logic [CW-1:0] drop, input logic [PW-1:0] pix);
    checkOutput({tag, "_wr_ready"}, 16'(rdy), 16'(m_wr[k] >= 0));
    if (m_wr[k] >= 0) checkOutput({tag, "_wr_idx"}, 16'(widx), 16'(m_wr[k]));
    checkOutput({tag, "_disp_idx"}, 16'(didx), 16'(m_disp[k]));
    checkOutput({tag, "_overflow"}, 16'(ovf), 16'(m_ovf[k]));
    checkOutput({tag, "_repeated"}, 16'(rep), 16'(m_rep[k]));
    checkOutput({tag, "_dropped"}, 16'(drop), 16'(m_drop[k]));
    if (m_pix[k] >= 0) checkOutput({tag, "_pix"}, 16'(pix), 16'(m_pix[k]));
  endtask

  always @(negedge pixel_clk) begin
    checkDut(0, "u3", ready3, widx3, disp3, ovf3, rep3, drop3, pix3);
    checkDut(1, "u2", ready2, widx2, disp2, ovf2, rep2, drop2, pix2);
  end

  task automatic applyStimulus(input logic rst, input logic we, input int wa, input int wd,
                               input logic fd, input logic fc, input int ra);
    RESET = rst; wr_en = we; wr_addr = AW'(wa); wr_data = PW'(wd);
    wr_frame_done = fd; frame_complete = fc; rd_addr = AW'(ra);
    @(posedge pixel_clk);
    modelStep(0, 3);
    modelStep(1, 2);
    @(negedge pixel_clk);
  endtask

  task automatic cyc(input logic we, input int wa, input int wd, input logic fd, input logic fc,
                     input int ra);
    applyStimulus(1'b0, we, wa, wd, fd, fc, ra);
  endtask

  initial begin
    foreach (m_mem[k, b, a]) m_mem[k][b][a] = -1;

    // Reset, then read address 5 before anything is published.
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 5);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    checkOutput("lit_reset_pix3", 16'(pix3), 16'(BLANK));
    checkOutput("lit_reset_pix2", 16'(pix2), 16'(BLANK));
    checkOutput("lit_reset_disp3", 16'(disp3), 16'd0);
    checkOutput("lit_reset_widx3", 16'(widx3), 16'd1);
    checkOutput("lit_reset_ready3", 16'(ready3), 16'd1);

    // First publish and swap.
    cyc(1, 5, 'hAA, 0, 0, 5);
    cyc(0, 0, 0, 1, 0, 5);
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    checkOutput("lit_first_pix3", 16'(pix3), 16'h00AA);
    checkOutput("lit_first_pix2", 16'(pix2), 16'h00AA);
    checkOutput("lit_first_disp3", 16'(disp3), 16'd1);
    checkOutput("lit_first_widx3", 16'(widx3), 16'd2);

    // Two-bank stall, overflow, and release on swap.
    cyc(1, 3, 'h33, 0, 0, 3);
    cyc(0, 0, 0, 1, 0, 3);
    checkOutput("lit_stall_ready2", 16'(ready2), 16'd0);
    checkOutput("lit_stall_ready3", 16'(ready3), 16'd1);
    cyc(1, 3, 'h55, 0, 0, 3);
    checkOutput("lit_ovf2", 16'(ovf2), 16'd1);
    checkOutput("lit_ovf3", 16'(ovf3), 16'd0);
    cyc(0, 0, 0, 0, 1, 3);
    checkOutput("lit_release_ready2", 16'(ready2), 16'd1);
    checkOutput("lit_release_widx2", 16'(widx2), 16'd1);
    cyc(0, 0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 0, 3);
    checkOutput("lit_stall_pix2", 16'(pix2), 16'h0033);

    // Two publishes before one swap drop the older frame; an empty swap repeats.
    cyc(1, 7, 'h11, 0, 0, 7);
    cyc(0, 0, 0, 1, 0, 7);
    cyc(1, 7, 'h22, 0, 0, 7);
    cyc(0, 0, 0, 1, 0, 7);
    cyc(0, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 0, 7);
    cyc(0, 0, 0, 0, 0, 7);
    checkOutput("lit_drop3", 16'(drop3), 16'd1);
    checkOutput("lit_drop_pix3", 16'(pix3), 16'h0022);
    checkOutput("lit_drop_pix2", 16'(pix2), 16'h0011);
    cyc(0, 0, 0, 0, 1, 7);
    checkOutput("lit_repeat3", 16'(rep3), 16'd1);

    // Publish and swap in the same cycle, with reads straddling the swap.
    cyc(1, 7, 'h77, 0, 0, 7);
    cyc(0, 0, 0, 1, 0, 7);
    cyc(1, 7, 'h78, 0, 0, 7);
    cyc(0, 0, 0, 1, 1, 7);
    cyc(0, 0, 0, 0, 0, 7);
    checkOutput("lit_straddle_old3", 16'(pix3), 16'h0022);
    cyc(0, 0, 0, 0, 0, 7);
    checkOutput("lit_straddle_new3", 16'(pix3), 16'h0078);
    checkOutput("lit_simul_disp3", 16'(disp3), 16'd2);
    checkOutput("lit_simul_drop3", 16'(drop3), 16'd2);
    checkOutput("lit_simul_widx3", 16'(widx3), 16'd0);

    // Last valid address versus first out-of-range address.
    cyc(1, FP - 1, 'h19, 0, 0, 0);
    cyc(1, FP, 'hDD, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, FP - 1);
    cyc(0, 0, 0, 0, 0, FP);
    checkOutput("lit_edge_pix3", 16'(pix3), 16'h0019);
    cyc(0, 0, 0, 0, 0, FP);
    checkOutput("lit_oor_pix3", 16'(pix3), 16'(BLANK));

    // Repeat counter saturation.
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 0);
    checkOutput("lit_sat_rep3", 16'(rep3), 16'(MAXC));
    checkOutput("lit_sat_rep2", 16'(rep2), 16'(MAXC));

    // Reset in the middle of a frame with every input active.
    cyc(1, 2, 'h42, 0, 0, 2);
    cyc(0, 0, 0, 1, 0, 2);
    cyc(1, 2, 'h43, 0, 0, 2);
    applyStimulus(1'b1, 1, 4, 'h05, 1, 1, 4);
    checkOutput("lit_rst_disp3", 16'(disp3), 16'd0);
    checkOutput("lit_rst_widx3", 16'(widx3), 16'd1);
    checkOutput("lit_rst_ready2", 16'(ready2), 16'd1);
    checkOutput("lit_rst_ovf2", 16'(ovf2), 16'd0);
    checkOutput("lit_rst_rep3", 16'(rep3), 16'd0);
    checkOutput("lit_rst_drop3", 16'(drop3), 16'd0);
    checkOutput("lit_rst_pix3", 16'(pix3), 16'(BLANK));
    cyc(0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    checkOutput("lit_post_rst_pix3", 16'(pix3), 16'(BLANK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
